alu_upper_immediate_utype: RTL and testbench

Parametrised U-type execution unit for the rv32i core's `alu_rv` group. It executes both U-type instructions: `lui` (opcode 6..2=0x0D) and `auipc` (opcode 6..2=0x05). It replaces the single-instruction tri-state result driver with a valid/ready handshake and a 2-entry result buffer, so back-pressure from writeback never drops a result. It sits between decode (immediate, pc, rd index) and the register-file writeback arbiter.

---
 rtl/alu_upper_immediate_utype_if.sv | 47 ++++
 rtl/alu_upper_immediate_utype.sv | 147 ++++++++++++++
 tb/tb_alu_upper_immediate_utype.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_upper_immediate_utype_if.sv
// Handshake bundle for the U-type unit: decode-side op in, writeback-side result out.
// master = environment (decode + writeback), slave = execution unit.
interface alu_upper_immediate_utype_if #(
    parameter int XLEN      = 32,
    parameter int IMM_W     = 20,
    parameter int REG_IDX_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 is_auipc;
    logic [IMM_W-1:0]     immediate20_utype;
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rd_index;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      rd_value;
    logic [REG_IDX_W-1:0] rd_index_out;
    logic                 rd_write;

    modport master (
        output in_valid,
        output is_auipc,
        output immediate20_utype,
        output pc,
        output rd_index,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  rd_value,
        input  rd_index_out,
        input  rd_write
    );

    modport slave (
        input  in_valid,
        input  is_auipc,
        input  immediate20_utype,
        input  pc,
        input  rd_index,
        input  out_ready,
        output in_ready,
        output out_valid,
        output rd_value,
        output rd_index_out,
        output rd_write
    );
endinterface

// File: rtl/alu_upper_immediate_utype.sv
// U-type execution unit (lui / auipc) with a 2-entry result buffer.
// Optional retire counters: define ALU_UPPER_IMMEDIATE_PERF_EN.
module alu_upper_immediate_utype #(
    parameter int XLEN      = 32,
    parameter int IMM_W     = 20,
    parameter int REG_IDX_W = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    alu_upper_immediate_utype_if.slave bus
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
    ,
    output logic [31:0] lui_retired,
    output logic [31:0] auipc_retired
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]      value;
        logic [REG_IDX_W-1:0] idx;
        logic                 wr;
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        logic                 auipc;
`endif
    } entry_t;

    logic [1:0] count_q, count_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    entry_t     new_entry;

    logic [IMM_W+11:0] upper_raw;
    logic [XLEN-1:0]   upper_val;
    logic [XLEN-1:0]   auipc_sum;
    logic              push;
    logic              pop;

`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
    logic [31:0] lui_cnt_q, lui_cnt_d;
    logic [31:0] auipc_cnt_q, auipc_cnt_d;
`endif

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Build the result entry for the op currently offered by decode.
    always_comb begin
        upper_raw = {bus.immediate20_utype, 12'b0};
        upper_val = XLEN'($signed(upper_raw));
        auipc_sum = bus.pc + upper_val;
        new_entry = '0;
        new_entry.idx = bus.rd_index;
        new_entry.wr  = (bus.rd_index != '0);
        if (new_entry.wr) begin
            new_entry.value = bus.is_auipc ? auipc_sum : upper_val;
        end
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        new_entry.auipc = bus.is_auipc;
`endif
    end

    // Buffer next state: flush wins, else push/pop shift the two slots.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = new_entry;
                    end else begin
                        tail_d = new_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = (count_q == 2'd2) ? tail_q : '0;
                    tail_d  = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // only reachable with one entry held
                    head_d = new_entry;
                    tail_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
    // Count retired ops by type on every non-flushed pop.
    always_comb begin
        lui_cnt_d   = lui_cnt_q;
        auipc_cnt_d = auipc_cnt_q;
        if (!flush && pop) begin
            if (head_q.auipc) begin
                auipc_cnt_d = auipc_cnt_q + 32'd1;
            end else begin
                lui_cnt_d = lui_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lui_cnt_q   <= '0;
            auipc_cnt_q <= '0;
        end else begin
            lui_cnt_q   <= lui_cnt_d;
            auipc_cnt_q <= auipc_cnt_d;
        end
    end

    assign lui_retired   = lui_cnt_q;
    assign auipc_retired = auipc_cnt_q;
`endif

    // Buffer registers; reset drops every entry immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign bus.rd_value     = bus.out_valid ? head_q.value : '0;
    assign bus.rd_index_out = bus.out_valid ? head_q.idx : '0;
    assign bus.rd_write     = bus.out_valid & head_q.wr;

endmodule

// File: tb/tb_alu_upper_immediate_utype.sv
// Bench for alu_upper_immediate_utype: queue model checked every cycle
// plus directed literal cases (lui, auipc wrap, x0, stall, flush, reset, XLEN=64).
module tb_alu_upper_immediate_utype;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic flush64 = 1'b0;

    always #5 clock = ~clock;

    alu_upper_immediate_utype_if #(.XLEN(32)) bus ();
    alu_upper_immediate_utype_if #(.XLEN(64)) b64 ();

`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
    logic [31:0] lui_ret, auipc_ret, lui64, auipc64;
`endif

    alu_upper_immediate_utype #(.XLEN(32)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .bus(bus.slave)
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        ,
        .lui_retired(lui_ret),
        .auipc_retired(auipc_ret)
`endif
    );

    alu_upper_immediate_utype #(.XLEN(64)) dut64 (
        .clock(clock),
        .reset(reset),
        .flush(flush64),
        .bus(b64.slave)
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        ,
        .lui_retired(lui64),
        .auipc_retired(auipc64)
`endif
    );

    typedef struct {
        logic [31:0] value;
        logic [4:0]  idx;
        logic        wr;
        logic        auipc;
    } ment_t;

    ment_t       mq[$];
    int unsigned m_lui;
    int unsigned m_auipc;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: architectural result rules and a 2-deep queue.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_lui = 0;
            m_auipc = 0;
        end else begin
            ment_t e;
            bit acc;
            bit pp;
            acc = bus.in_valid && (mq.size() < 2);
            pp  = bus.out_ready && (mq.size() > 0);
            e.idx   = bus.rd_index;
            e.wr    = (bus.rd_index != 0);
            e.auipc = bus.is_auipc;
            if (bus.rd_index == 0) e.value = 0;
            else if (bus.is_auipc) e.value = bus.pc + {bus.immediate20_utype, 12'h000};
            else e.value = {bus.immediate20_utype, 12'h000};
            if (flush) begin
                mq.delete();
            end else begin
                if (pp) begin
                    if (mq[0].auipc) m_auipc++;
                    else m_lui++;
                    void'(mq.pop_front());
                end
                if (acc) mq.push_back(e);
            end
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clock) begin
        check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        check("in_ready", 64'(bus.in_ready), 64'(mq.size() != 2));
        if (mq.size() != 0) begin
            check("rd_value", 64'(bus.rd_value), 64'(mq[0].value));
            check("rd_index_out", 64'(bus.rd_index_out), 64'(mq[0].idx));
            check("rd_write", 64'(bus.rd_write), 64'(mq[0].wr));
        end else begin
            check("rd_value_idle", 64'(bus.rd_value), 64'd0);
            check("rd_write_idle", 64'(bus.rd_write), 64'd0);
        end
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        check("lui_retired", 64'(lui_ret), 64'(m_lui));
        check("auipc_retired", 64'(auipc_ret), 64'(m_auipc));
`endif
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic op(input bit v, input bit au, input logic [19:0] imm,
                      input logic [31:0] p, input logic [4:0] rd);
        bus.in_valid = v;
        bus.is_auipc = au;
        bus.immediate20_utype = imm;
        bus.pc = p;
        bus.rd_index = rd;
    endtask

    initial begin
        int unsigned snap_l;
        int unsigned snap_a;
        op(0, 0, 0, 0, 0);
        bus.out_ready = 1'b0;
        b64.in_valid = 0;
        b64.is_auipc = 0;
        b64.immediate20_utype = 0;
        b64.pc = 0;
        b64.rd_index = 0;
        b64.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;

        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset rd_value", 64'(bus.rd_value), 64'd0);
        check("reset rd_index_out", 64'(bus.rd_index_out), 64'd0);
        check("reset rd_write", 64'(bus.rd_write), 64'd0);

        // lui on both widths
        bus.out_ready = 1'b1;
        op(1, 0, 20'hABCDE, 32'h0, 5'd5);
        b64.in_valid = 1;
        b64.immediate20_utype = 20'h80000;
        b64.rd_index = 5'd3;
        cyc();
        op(0, 0, 0, 0, 0);
        b64.in_valid = 0;
        check("lui out_valid", 64'(bus.out_valid), 64'd1);
        check("lui rd_value", 64'(bus.rd_value), 64'hABCDE000);
        check("lui rd_index_out", 64'(bus.rd_index_out), 64'd5);
        check("lui rd_write", 64'(bus.rd_write), 64'd1);
        check("lui64 rd_value", b64.rd_value, 64'hFFFFFFFF80000000);
        cyc();
        check("lui popped", 64'(bus.out_valid), 64'd0);

        // auipc wrap
        op(1, 1, 20'h00002, 32'hFFFFF000, 5'd7);
        cyc();
        op(0, 0, 0, 0, 0);
        check("auipc wrap", 64'(bus.rd_value), 64'h00001000);
        cyc();

        // rd = x0
        op(1, 0, 20'hFFFFF, 32'h0, 5'd0);
        cyc();
        op(0, 0, 0, 0, 0);
        check("x0 out_valid", 64'(bus.out_valid), 64'd1);
        check("x0 rd_write", 64'(bus.rd_write), 64'd0);
        check("x0 rd_value", 64'(bus.rd_value), 64'd0);
        cyc();
        check("x0 popped", 64'(bus.out_valid), 64'd0);

        // back-pressure: A, B, C
        bus.out_ready = 1'b0;
        op(1, 0, 20'h00001, 0, 5'd1);
        cyc();
        op(1, 0, 20'h00002, 0, 5'd2);
        cyc();
        op(1, 0, 20'h00003, 0, 5'd3);
        check("stall in_ready", 64'(bus.in_ready), 64'd0);
        check("stall head A", 64'(bus.rd_value), 64'h00001000);
        cyc();
        check("stall hold", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        cyc();
        check("after pop A in_ready", 64'(bus.in_ready), 64'd1);
        check("head B", 64'(bus.rd_value), 64'h00002000);
        cyc();
        op(0, 0, 0, 0, 0);
        check("head C", 64'(bus.rd_value), 64'h00003000);
        check("head C idx", 64'(bus.rd_index_out), 64'd3);
        cyc();
        check("drained", 64'(bus.out_valid), 64'd0);

        // flush with full buffer and simultaneous push
        bus.out_ready = 1'b0;
        op(1, 1, 20'h00010, 32'h100, 5'd4);
        cyc();
        op(1, 0, 20'h00020, 0, 5'd6);
        cyc();
        snap_l = m_lui;
        snap_a = m_auipc;
        op(1, 0, 20'h00030, 0, 5'd8);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        op(0, 0, 0, 0, 0);
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        check("flush in_ready", 64'(bus.in_ready), 64'd1);
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        check("flush lui cnt", 64'(lui_ret), 64'(snap_l));
        check("flush auipc cnt", 64'(auipc_ret), 64'(snap_a));
`endif

        // async reset between edges with two entries held
        op(1, 0, 20'h0000A, 0, 5'd10);
        cyc();
        op(1, 0, 20'h0000B, 0, 5'd11);
        cyc();
        op(0, 0, 0, 0, 0);
        check("pre-reset full", 64'(bus.in_ready), 64'd0);
        #1 reset = 1'b1;
        #1;
        check("areset out_valid", 64'(bus.out_valid), 64'd0);
        check("areset rd_value", 64'(bus.rd_value), 64'd0);
        check("areset rd_write", 64'(bus.rd_write), 64'd0);
        check("areset in_ready", 64'(bus.in_ready), 64'd1);
        #2 reset = 1'b0;
        cyc();
        bus.out_ready = 1'b1;
        op(1, 0, 20'h12345, 0, 5'd9);
        cyc();
        op(0, 0, 0, 0, 0);
        check("post-reset lui", 64'(bus.rd_value), 64'h12345000);
        check("post-reset idx", 64'(bus.rd_index_out), 64'd9);
        cyc();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               20'($urandom), $urandom,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            cyc();
        end
        op(0, 0, 0, 0, 0);
        flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
